// File: rtl/psk_qam_mapper.sv
// Serial-bit to constellation mapper: BPSK, QPSK and Gray 16-QAM
// with per-symbol mode, frame-end padding and ready/valid on both sides.
module psk_qam_mapper #(
  parameter int IQ_W     = 16,
  parameter int QPSK_AMP = 23169,
  parameter int BPSK_AMP = 32767,
  parameter int QAM_LO   = 10362,
  parameter int QAM_HI   = 31086
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [1:0]        i_mode,
  input  logic              i_data,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic [2*IQ_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  input  logic              i_ready
);

  typedef enum logic [1:0] {
    M_BPSK  = 2'd0,
    M_QPSK  = 2'd1,
    M_QAM16 = 2'd2
  } mode_e;

  localparam logic [IQ_W-1:0] BPSK_P = IQ_W'(BPSK_AMP);
  localparam logic [IQ_W-1:0] QPSK_P = IQ_W'(QPSK_AMP);
  localparam logic [IQ_W-1:0] LO_P   = IQ_W'(QAM_LO);
  localparam logic [IQ_W-1:0] HI_P   = IQ_W'(QAM_HI);

  logic [1:0]        cnt_q, cnt_d;
  logic [3:0]        sr_q, sr_d;
  mode_e             mode_q, mode_d;
  logic [2*IQ_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  logic              accept;
  logic              done;
  mode_e             mode_cur;
  mode_e             mode_in;
  logic [1:0]        last_idx;
  logic [3:0]        bits;
  logic [IQ_W-1:0]   i_mag, q_mag;
  logic [IQ_W-1:0]   i_val, q_val;

  assign o_ready = !valid_q || i_ready;
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;

  // Reserved mode code falls back to QPSK
  always_comb begin
    mode_in = M_QPSK;
    unique case (i_mode)
      2'd0:    mode_in = M_BPSK;
      2'd2:    mode_in = M_QAM16;
      default: mode_in = M_QPSK;
    endcase
  end

  always_comb begin
    accept   = i_valid && o_ready;
    mode_cur = (cnt_q == 2'd0) ? mode_in : mode_q;
    last_idx = 2'd1;
    unique case (mode_cur)
      M_BPSK:  last_idx = 2'd0;
      M_QAM16: last_idx = 2'd3;
      default: last_idx = 2'd1;
    endcase
    bits         = sr_q;
    bits[cnt_q]  = i_data;
    done         = accept && ((cnt_q == last_idx) || i_last);
  end

  // Unreceived bits stay zero in the shift register, giving the padding
  always_comb begin
    i_mag = QPSK_P;
    q_mag = QPSK_P;
    unique case (mode_cur)
      M_BPSK: begin
        i_mag = BPSK_P;
        q_mag = '0;
      end
      M_QAM16: begin
        i_mag = bits[2] ? HI_P : LO_P;
        q_mag = bits[3] ? HI_P : LO_P;
      end
      default: begin
        i_mag = QPSK_P;
        q_mag = QPSK_P;
      end
    endcase
    i_val = bits[0] ? (IQ_W'(0) - i_mag) : i_mag;
    q_val = (bits[1] && mode_cur != M_BPSK)
          ? (IQ_W'(0) - q_mag) : q_mag;
  end

  always_comb begin
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    mode_d  = mode_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (valid_q && i_ready)
      valid_d = 1'b0;
    if (accept) begin
      if (cnt_q == 2'd0)
        mode_d = mode_in;
      if (done) begin
        cnt_d   = 2'd0;
        sr_d    = '0;
        data_d  = {i_val, q_val};
        valid_d = 1'b1;
        last_d  = i_last;
      end else begin
        cnt_d = cnt_q + 2'd1;
        sr_d  = bits;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q   <= '0;
      sr_q    <= '0;
      mode_q  <= M_QPSK;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_psk_qam_mapper.sv
// Directed and randomised checks of psk_qam_mapper against
// an arithmetic constellation model.
module tb_psk_qam_mapper;

  localparam int IQ_W = 16;
  localparam int QPSK = 23169;
  localparam int BPSK = 32767;
  localparam int LO   = 10362;
  localparam int HI   = 31086;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      mode;
  logic            din;
  logic            vin;
  logic            lin;
  logic            rdy_o;
  logic [31:0]     dout;
  logic            vout;
  logic            lout;
  logic            rdy_i;

  int checks   = 0;
  int failures = 0;

  psk_qam_mapper #(
    .IQ_W(IQ_W), .QPSK_AMP(QPSK), .BPSK_AMP(BPSK),
    .QAM_LO(LO), .QAM_HI(HI)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_mode(mode),
    .i_data(din), .i_valid(vin), .i_last(lin),
    .o_ready(rdy_o), .o_data(dout), .o_valid(vout),
    .o_last(lout), .i_ready(rdy_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input bit b);
    return b ? -1 : 1;
  endfunction

  // Symbol value from arrival-ordered bits, missing bits taken as 0
  function automatic logic [31:0] sym(input int m, input bit b[$]);
    int iv, qv;
    bit p[4];
    for (int k = 0; k < 4; k++) p[k] = (k < b.size()) ? b[k] : 1'b0;
    if (m == 0) begin
      iv = sgn(p[0]) * BPSK;
      qv = 0;
    end else if (m == 2) begin
      iv = sgn(p[0]) * (p[2] ? HI : LO);
      qv = sgn(p[1]) * (p[3] ? HI : LO);
    end else begin
      iv = sgn(p[0]) * QPSK;
      qv = sgn(p[1]) * QPSK;
    end
    return {16'(iv), 16'(qv)};
  endfunction

  function automatic bit in_set(input logic [15:0] v);
    return v == 16'(LO) || v == 16'(HI) ||
           v == 16'(-LO) || v == 16'(-HI);
  endfunction

  function automatic int lvl(input logic [15:0] v);
    if (v == 16'(-HI)) return 0;
    if (v == 16'(-LO)) return 1;
    if (v == 16'(LO))  return 2;
    return 3;
  endfunction

  task automatic drive(input bit d, input logic [1:0] m, input bit l);
    vin  = 1'b1;
    din  = d;
    mode = m;
    lin  = l;
    @(posedge clk); #1;
    vin = 1'b0;
    lin = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vin = 1'b0;
    lin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [1:0]  gcode [4];
  logic [31:0] held;
  bit          cb[$];
  bit          mq[$];
  int          mmode;
  bit          vld_m, last_m, ready_m, acc, v, l, d;
  logic [31:0] exp_m;
  int          m, n;

  initial begin
    rst = 1'b1; mode = 2'd1; din = 1'b0;
    vin = 1'b0; lin = 1'b0; rdy_i = 1'b1;
    do_reset();
    chk("rst_data", dout, 32'h0);
    chk("rst_valid", vout, 1'b0);
    chk("rst_last", lout, 1'b0);
    chk("rst_ready", rdy_o, 1'b1);

    drive(1'b0, 2'd1, 1'b0);
    chk("qpsk_wait", vout, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    chk("qpsk_data", dout, 32'h5A81_A57F);
    chk("qpsk_valid", vout, 1'b1);
    chk("qpsk_last", lout, 1'b0);
    @(posedge clk); #1;
    chk("qpsk_drop", vout, 1'b0);

    drive(1'b1, 2'd2, 1'b0);
    drive(1'b0, 2'd2, 1'b0);
    drive(1'b0, 2'd2, 1'b0);
    drive(1'b1, 2'd2, 1'b0);
    chk("qam_data", dout, 32'hD786_796E);

    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 4; k++) begin
        drive(c[k], 2'd2, 1'b0);
        cb.push_back(c[k]);
      end
      chk("sweep_data", dout, sym(2, cb));
      chk("sweep_iset", in_set(dout[31:16]), 1'b1);
      chk("sweep_qset", in_set(dout[15:0]), 1'b1);
      gcode[lvl(dout[31:16])] = {c[0], c[2]};
      cb.delete();
    end
    for (int k = 0; k < 3; k++)
      chk("gray_adj", $countones(gcode[k] ^ gcode[k+1]), 1);

    drive(1'b1, 2'd0, 1'b0);
    chk("bpsk1_data", dout, 32'h8001_0000);
    chk("bpsk1_valid", vout, 1'b1);
    drive(1'b0, 2'd0, 1'b0);
    chk("bpsk0_data", dout, 32'h7FFF_0000);
    chk("bpsk0_valid", vout, 1'b1);
    @(posedge clk); #1;
    chk("bpsk_drop", vout, 1'b0);

    rdy_i = 1'b0;
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b0, 2'd1, 1'b0);
    chk("bp_data", dout, 32'hA57F_5A81);
    held = dout;
    vin = 1'b1; din = 1'b0; mode = 2'd1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", rdy_o, 1'b0);
      @(posedge clk); #1;
      chk("bp_hold", dout, held);
      chk("bp_valid", vout, 1'b1);
    end
    rdy_i = 1'b1;
    #1 chk("bp_release", rdy_o, 1'b1);
    @(posedge clk); #1;
    vin = 1'b0;
    chk("bp_drop", vout, 1'b0);
    drive(1'b0, 2'd1, 1'b0);
    chk("bp_next", dout, 32'h5A81_5A81);
    chk("bp_next_v", vout, 1'b1);

    drive(1'b1, 2'd2, 1'b0);
    drive(1'b1, 2'd1, 1'b1);
    chk("pad_data", dout, 32'hD786_D786);
    chk("pad_last", lout, 1'b1);
    drive(1'b0, 2'd1, 1'b0);
    drive(1'b0, 2'd1, 1'b0);
    chk("after_pad", dout, 32'h5A81_5A81);
    chk("after_pad_last", lout, 1'b0);

    drive(1'b0, 2'd1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_data", dout, 32'h0);
    chk("mrst_valid", vout, 1'b0);
    chk("mrst_last", lout, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    chk("mrst_wait", vout, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    chk("mrst_data2", dout, 32'hA57F_A57F);

    do_reset();
    vld_m = 1'b0; last_m = 1'b0; exp_m = '0;
    mq.delete(); mmode = 1;
    for (int t = 0; t < 600; t++) begin
      v = ($urandom_range(0, 3) != 0);
      d = $urandom_range(0, 1);
      l = ($urandom_range(0, 7) == 0);
      m = $urandom_range(0, 3);
      vin = v; din = d; lin = l; mode = 2'(m);
      rdy_i = ($urandom_range(0, 3) != 0);
      #1;
      ready_m = !vld_m || rdy_i;
      chk("rnd_ready", rdy_o, ready_m);
      acc = v && ready_m;
      if (vld_m && rdy_i) vld_m = 1'b0;
      if (acc) begin
        if (mq.size() == 0) mmode = (m == 3) ? 1 : m;
        mq.push_back(d);
        n = (mmode == 0) ? 1 : (mmode == 2) ? 4 : 2;
        if (mq.size() == n || l) begin
          exp_m  = sym(mmode, mq);
          vld_m  = 1'b1;
          last_m = l;
          mq.delete();
        end
      end
      @(posedge clk); #1;
      chk("rnd_valid", vout, vld_m);
      if (vld_m) begin
        chk("rnd_data", dout, exp_m);
        chk("rnd_last", lout, last_m);
      end
    end
    vin = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psk_qam_mapper.md
Name: psk_qam_mapper

Overview:
Parametrised constellation mapper, successor to the fixed QPSK mapper. It accumulates serial input bits into symbols and supports BPSK, QPSK and Gray-coded 16-QAM, selectable per symbol. It adds ready/valid backpressure on both sides, frame-end (last) handling with zero padding of partial symbols, and parametrised amplitudes and widths. It sits between the bit source (scrambler/coder) and the pulse-shaping filter.

Parameters:
IQ_W, 16, width of each I and Q component (signed two's complement)
QPSK_AMP, 23169, QPSK component magnitude
BPSK_AMP, 32767, BPSK I magnitude
QAM_LO, 10362, 16-QAM inner level magnitude
QAM_HI, 31086, 16-QAM outer level magnitude

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_mode  in  2  0=BPSK, 1=QPSK, 2=16-QAM, 3=reserved (treated as QPSK)
i_data  in  1  input bit
i_valid  in  1  input bit valid
i_last  in  1  marks the final bit of a frame
o_ready  out  1  mapper can accept a bit this cycle
o_data  out  2*IQ_W  symbol {I[2*IQ_W-1:IQ_W], Q[IQ_W-1:0]}
o_valid  out  1  o_data valid
o_last  out  1  symbol carries the frame-final bit
i_ready  in  1  downstream accepts the symbol

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_reset. Reset values: o_data=0, o_valid=0, o_last=0, bit counter=0, shift register=0, latched mode=QPSK. A partial symbol is discarded on reset.
- o_ready = !o_valid || i_ready (combinational). A bit is accepted when i_valid && o_ready.
- Bits per symbol N: BPSK 1, QPSK 2, 16-QAM 4.
- i_mode is sampled only on a bit accepted at counter==0, and is latched for the rest of the symbol. Mode changes mid-symbol are ignored until the next symbol.
- Bits are numbered b0..b(N-1) in arrival order. The counter increments on each accepted bit.
- Symbol completion occurs on the accepted bit where counter==N-1, or earlier when i_last=1. On early completion, the missing bits are 0.
- On completion, the next clock registers o_data, sets o_valid=1, sets o_last=i_last, and resets the counter to 0. Latency is 1 cycle from the final accepted bit.
- Mapping (bit 0 -> positive, 1 -> negative; negation is IQ_W-bit two's complement):
  - BPSK: I = b0 ? -BPSK_AMP : +BPSK_AMP; Q = 0.
  - QPSK: I from b0, Q from b1, magnitude QPSK_AMP.
  - 16-QAM: I sign from b0 and magnitude from b2; Q sign from b1 and magnitude from b3. Magnitude bit 0 -> QAM_LO, 1 -> QAM_HI. Level order -HI, -LO, +LO, +HI has codes 11, 10, 00, 01 (Gray).
- Output hold:
  - While o_valid && !i_ready, o_data and o_last are held stable and no bits are accepted.
  - When o_valid && i_ready and no new completion occurs, o_valid drops to 0 next cycle.
  - When o_valid && i_ready and a completion occurs in the same cycle, o_data is replaced and o_valid stays 1 (full throughput: 1 symbol per cycle in BPSK).
- o_valid deasserts only on handshake or reset.
- Bits that do not complete a symbol still require o_ready. This is intentional; it keeps o_ready free of any counter dependence.

Test Plan:
- QPSK, bits 0,1 with i_ready=1 -> one cycle after the second bit: o_data=32'h5A81_A57F, o_valid=1 for 1 cycle, o_last=0.
- 16-QAM, bits 1,0,0,1 -> o_data=32'hD786_796E. Then sweep all 16 codes: every I/Q value is one of ±10362, ±31086, and adjacent levels differ by 1 bit.
- BPSK stream 1,0 back-to-back, i_ready=1 -> o_data 32'h8001_0000 then 32'h7FFF_0000 on consecutive cycles, o_valid continuous.
- Backpressure: i_ready=0 while o_valid=1 -> o_ready=0, o_data stable for 5 cycles, no bits lost. After i_ready=1, the following symbols are correct and in order.
- 16-QAM with i_last on b1 (bits 1,1) -> padded symbol {-10362,-10362}=32'hD786_D786 with o_last=1. A mode change to QPSK during that symbol has no effect until the next symbol.
- Reset mid-symbol (after 1 QPSK bit) -> all outputs 0. The next bits 1,1 produce 32'hA57F_A57F, with no leftover bit from before reset.
